// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory-game card board.
//   - Board word field positions (active, discovered, colour).
//   - Card address range and number of pairs in a full game.
//   - Controller state encoding, also exported on the debug state output.
//   - is_card(): true for addresses that hold a playable card.
package memory_game_pkg;

    localparam int WORD_W      = 14;
    localparam int ADDR_W      = 4;
    localparam int NUM_ENTRIES = 16;

    localparam int ACTIVE_BIT = 0;
    localparam int DISC_BIT   = 1;
    localparam int COLOR_MSB  = 13;
    localparam int COLOR_LSB  = 2;

    localparam logic [ADDR_W-1:0] FIRST_CARD = 4'd1;
    localparam logic [ADDR_W-1:0] LAST_CARD  = 4'd12;
    localparam logic [2:0]        NUM_PAIRS  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_READY     = 3'd2,
        ST_ONE_UP    = 3'd3,
        ST_COMPARE   = 3'd4,
        ST_HIDE_WAIT = 3'd5,
        ST_WON       = 3'd6
    } state_t;

    function automatic logic is_card(input logic [ADDR_W-1:0] idx);
        return (idx >= FIRST_CARD) && (idx <= LAST_CARD);
    endfunction

endpackage

// File: rtl/card_board_ctl_if.sv
// Bus between the card-board controller and its environment (colour
// generator, player input, VGA renderer).
//   start              : begin a new game
//   cc_enable/cc_data/cc_address : colour generator enable and its output word
//   flip_req/flip_idx/flip_ack   : player flip request
//   rd_addr/rd_data    : renderer read port (1-cycle latency)
//   busy/pair_count/moves/game_won : game status
//   state_dbg          : controller state, for observation only
// Flip handshake: flip_req is a level qualified by flip_idx and sampled
// every clock. flip_ack is a one-cycle pulse in the cycle after an accepted
// request; a request that is not acked was dropped, not queued. A requester
// holding flip_req for several cycles on the same card gets one ack at most,
// because the card is face up after the first acceptance.
// Modports: master = environment side, slave = controller side.
interface card_board_ctl_if #(
    parameter int MOVES_W = 8
);
    logic                    start;
    logic                    cc_enable;
    logic [13:0]             cc_data;
    logic [3:0]              cc_address;
    logic                    flip_req;
    logic [3:0]              flip_idx;
    logic                    flip_ack;
    logic [3:0]              rd_addr;
    logic [13:0]             rd_data;
    logic                    busy;
    logic [2:0]              pair_count;
    logic [MOVES_W-1:0]      moves;
    logic                    game_won;
    memory_game_pkg::state_t state_dbg;

    modport master (
        output start, cc_data, cc_address, flip_req, flip_idx, rd_addr,
        input  cc_enable, flip_ack, rd_data, busy, pair_count, moves,
               game_won, state_dbg
    );

    modport slave (
        input  start, cc_data, cc_address, flip_req, flip_idx, rd_addr,
        output cc_enable, flip_ack, rd_data, busy, pair_count, moves,
               game_won, state_dbg
    );
endinterface

// File: rtl/card_regfile.sv
// 16 x 14-bit board register file.
//   clk, rst_n       : clock, async active-low clear of every entry
//   clr_all_i        : synchronous clear of every entry (new game)
//   we_i/waddr_i/wdata_i : full-word write, only card addresses take effect
//   set_disc_i/clr_disc_i/clr_active_i : per-entry bit updates, any number
//                      of entries in the same cycle
//   peek0_addr_i/peek0_o : combinational full-word view for flip checks
//   peek1_addr_i/peek1_color_o : combinational colour view for compare
//   raddr_i/rdata_o  : registered read port, returns pre-write contents
module card_regfile
    import memory_game_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_all_i,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      waddr_i,
    input  logic [WORD_W-1:0]      wdata_i,
    input  logic [NUM_ENTRIES-1:0] set_disc_i,
    input  logic [NUM_ENTRIES-1:0] clr_disc_i,
    input  logic [NUM_ENTRIES-1:0] clr_active_i,
    input  logic [ADDR_W-1:0]      peek0_addr_i,
    output logic [WORD_W-1:0]      peek0_o,
    input  logic [ADDR_W-1:0]      peek1_addr_i,
    output logic [11:0]            peek1_color_o,
    input  logic [ADDR_W-1:0]      raddr_i,
    output logic [WORD_W-1:0]      rdata_o
);
    logic [WORD_W-1:0] mem_q [NUM_ENTRIES];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (clr_all_i) begin
                    mem_q[i] <= '0;
                end else if (we_i && (waddr_i == ADDR_W'(i)) && is_card(ADDR_W'(i))) begin
                    mem_q[i] <= wdata_i;
                end else begin
                    // Set wins over clear; the controller never asks for both.
                    if (set_disc_i[i])      mem_q[i][DISC_BIT] <= 1'b1;
                    else if (clr_disc_i[i]) mem_q[i][DISC_BIT] <= 1'b0;
                    if (clr_active_i[i])    mem_q[i][ACTIVE_BIT] <= 1'b0;
                end
            end
        end
    end

    assign peek0_o       = mem_q[peek0_addr_i];
    assign peek1_color_o = mem_q[peek1_addr_i][COLOR_MSB:COLOR_LSB];
    assign rdata_o       = rdata_q;
endmodule

// File: rtl/card_board_ctl.sv
// Card-board controller: loads 12 card colours from the colour generator,
// then runs the two-flip memory game (reveal, compare, retire or hide).
//   clk, rst_n : clock, async active-low reset
//   bus        : card_board_ctl_if.slave (generator, flip, read port, status)
// Parameters: HIDE_CYCLES = cycles a mismatched pair stays face up,
//             MOVES_W = width of the saturating move counter.
module card_board_ctl
    import memory_game_pkg::*;
#(
    parameter int HIDE_CYCLES = 65_000_000,
    parameter int MOVES_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    card_board_ctl_if.slave   bus
);
    localparam int HIDE_W = $clog2(HIDE_CYCLES + 1);
    localparam logic [HIDE_W-1:0] HIDE_LAST = HIDE_W'(HIDE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    a_q, a_d, b_q, b_d;
    logic [HIDE_W-1:0]    hide_cnt_q, hide_cnt_d;
    logic [2:0]           pair_q, pair_d;
    logic [MOVES_W-1:0]   moves_q, moves_d;
    logic                 flip_ack_q, cc_enable_q, busy_q, won_q;

    logic                   clr_all, load_we, flip_ok, colours_equal;
    logic [NUM_ENTRIES-1:0] set_disc, clr_disc, clr_active;
    logic [ADDR_W-1:0]      peek0_addr;
    logic [WORD_W-1:0]      peek0;
    logic [11:0]            peek1_color;
    logic [WORD_W-1:0]      load_word;

    // Generator status bits are replaced by "active, face down" on load.
    logic unused_gen_flags;
    assign unused_gen_flags = ^bus.cc_data[1:0];
    assign load_word        = {bus.cc_data[COLOR_MSB:COLOR_LSB], 1'b0, 1'b1};

    // In COMPARE the first peek port looks at card A; otherwise it checks the
    // card being flipped.
    assign peek0_addr    = (state_q == ST_COMPARE) ? a_q : bus.flip_idx;
    assign colours_equal = (peek0[COLOR_MSB:COLOR_LSB] == peek1_color);
    assign load_we       = (state_q == ST_LOAD) && !bus.start && is_card(bus.cc_address);
    assign flip_ok       = bus.flip_req && !bus.start
                        && ((state_q == ST_READY) || (state_q == ST_ONE_UP))
                        && is_card(bus.flip_idx)
                        && peek0[ACTIVE_BIT] && !peek0[DISC_BIT];

    card_regfile u_regfile (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_all_i     (clr_all),
        .we_i          (load_we),
        .waddr_i       (bus.cc_address),
        .wdata_i       (load_word),
        .set_disc_i    (set_disc),
        .clr_disc_i    (clr_disc),
        .clr_active_i  (clr_active),
        .peek0_addr_i  (peek0_addr),
        .peek0_o       (peek0),
        .peek1_addr_i  (b_q),
        .peek1_color_o (peek1_color),
        .raddr_i       (bus.rd_addr),
        .rdata_o       (bus.rd_data)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        hide_cnt_d = hide_cnt_q;
        pair_d     = pair_q;
        moves_d    = moves_q;
        clr_all    = 1'b0;
        set_disc   = '0;
        clr_disc   = '0;
        clr_active = '0;
        if (bus.start) begin
            state_d = ST_LOAD;
            pair_d  = '0;
            moves_d = '0;
            clr_all = 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    // The last card written ends the load; the generator's
                    // own done flag is not needed.
                    if (load_we && (bus.cc_address == LAST_CARD)) state_d = ST_READY;
                end
                ST_READY: begin
                    if (flip_ok) begin
                        set_disc[bus.flip_idx] = 1'b1;
                        a_d     = bus.flip_idx;
                        state_d = ST_ONE_UP;
                    end
                end
                ST_ONE_UP: begin
                    if (flip_ok) begin
                        set_disc[bus.flip_idx] = 1'b1;
                        b_d     = bus.flip_idx;
                        state_d = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (moves_q != '1) moves_d = moves_q + MOVES_W'(1);
                    if (colours_equal) begin
                        clr_active[a_q] = 1'b1;
                        clr_active[b_q] = 1'b1;
                        pair_d  = pair_q + 3'd1;
                        state_d = ((pair_q + 3'd1) == NUM_PAIRS) ? ST_WON : ST_READY;
                    end else begin
                        hide_cnt_d = '0;
                        state_d    = ST_HIDE_WAIT;
                    end
                end
                ST_HIDE_WAIT: begin
                    if (hide_cnt_q == HIDE_LAST) begin
                        clr_disc[a_q] = 1'b1;
                        clr_disc[b_q] = 1'b1;
                        state_d       = ST_READY;
                    end else begin
                        hide_cnt_d = hide_cnt_q + HIDE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            hide_cnt_q  <= '0;
            pair_q      <= '0;
            moves_q     <= '0;
            flip_ack_q  <= 1'b0;
            cc_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hide_cnt_q  <= hide_cnt_d;
            pair_q      <= pair_d;
            moves_q     <= moves_d;
            flip_ack_q  <= flip_ok;
            cc_enable_q <= (state_d == ST_LOAD);
            busy_q      <= (state_d == ST_LOAD) || (state_d == ST_COMPARE)
                        || (state_d == ST_HIDE_WAIT);
            won_q       <= (state_d == ST_WON);
        end
    end

    assign bus.cc_enable  = cc_enable_q;
    assign bus.flip_ack   = flip_ack_q;
    assign bus.busy       = busy_q;
    assign bus.pair_count = pair_q;
    assign bus.moves      = moves_q;
    assign bus.game_won   = won_q;
    assign bus.state_dbg  = state_q;
endmodule
